// File: rtl/fixedpoint_pkg.sv
// rtl/fixedpoint_pkg.sv - width derivation and signed limit helpers shared by the fixed-point blocks
package fixedpoint_pkg;

  // Full-precision product fields: integer bits add, fraction bits add.
  function automatic int fp_prod_width(input int wa, input int wb);
    return wa + wb;
  endfunction

  function automatic int fp_max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [63:0] fp_smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fp_smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/comb_FixedPointZoom.sv
// rtl/comb_FixedPointZoom.sv - combinational signed WII.WIF to WOI.WOF conversion with round/saturate options
module comb_FixedPointZoom
  import fixedpoint_pkg::*;
#(
  parameter int WII   = 20,
  parameter int WIF   = 16,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic [WII+WIF-1:0] in,
  output logic [WOI+WOF-1:0] out,
  output logic               upflow,
  output logic               downflow
);

  localparam int WIN = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int FX  = fp_max_int(WIF, WOF);
  localparam int SH  = FX - WOF;
  // Two spare integer bits keep the rounding carry and the compare exact.
  localparam int WX  = fp_max_int(WII, WOI) + 2 + FX;
  localparam logic signed [WX-1:0] OMAX = WX'(fp_smax(WO));
  localparam logic signed [WX-1:0] OMIN = WX'(fp_smin(WO));

  logic signed [WX-1:0] ext;
  logic signed [WX-1:0] rnd;
  logic signed [WX-1:0] red;

  assign ext = $signed({{(WX-WIN){in[WIN-1]}}, in}) <<< (FX - WIF);

  generate
    if (ROUND != 0 && SH > 0) begin : g_round
      assign rnd = ext + $signed(WX'(1) << (SH - 1));
    end else begin : g_trunc
      assign rnd = ext;
    end
  endgenerate

  assign red      = rnd >>> SH;
  assign upflow   = (red > OMAX);
  assign downflow = (red < OMIN);

  always_comb begin
    out = red[WO-1:0];
    if (ROOF != 0) begin
      if (upflow) begin
        out = OMAX[WO-1:0];
      end else if (downflow) begin
        out = OMIN[WO-1:0];
      end
    end
  end

endmodule

// File: rtl/pipe_fixedpoint_mac.sv
// rtl/pipe_fixedpoint_mac.sv - 3-stage signed fixed-point MAC; FIXEDPOINT_MAC_ACC_SAT_EN saturates the accumulator
module pipe_fixedpoint_mac
  import fixedpoint_pkg::*;
#(
  parameter int WIIA   = 8,
  parameter int WIFA   = 8,
  parameter int WIIB   = 8,
  parameter int WIFB   = 8,
  parameter int WOI    = 8,
  parameter int WOF    = 8,
  parameter int WGUARD = 4,
  parameter int ROOF   = 1,
  parameter int ROUND  = 1
) (
  input  logic                 rstn,
  input  logic                 clk,
  input  logic                 i_en,
  input  logic                 i_last,
  input  logic [WIIA+WIFA-1:0] ina,
  input  logic [WIIB+WIFB-1:0] inb,
  output logic                 o_en,
  output logic [WOI+WOF-1:0]   out,
  output logic                 upflow,
  output logic                 downflow
);

  localparam int WRI  = fp_prod_width(WIIA, WIIB);
  localparam int WRF  = fp_prod_width(WIFA, WIFB);
  localparam int WP   = WRI + WRF;
  localparam int WACC = WRI + WGUARD + WRF;
  localparam int WO   = WOI + WOF;

  logic signed [WP-1:0]   prod_q, prod_d;
  logic                   en1_q, en1_d;
  logic                   last1_q, last1_d;
  logic signed [WACC-1:0] acc_q, acc_d;
  logic                   first_q, first_d;
  logic                   close2_q, close2_d;
  logic                   o_en_q, o_en_d;
  logic [WO-1:0]          out_q, out_d;
  logic                   up_q, up_d;
  logic                   dn_q, dn_d;

  logic signed [WACC-1:0] prod_ext;
  logic signed [WACC-1:0] base;
  logic [WO-1:0]          conv_out;
  logic                   conv_up;
  logic                   conv_dn;

`ifdef FIXEDPOINT_MAC_ACC_SAT_EN
  localparam logic [WACC-1:0] AMAX = {1'b0, {(WACC-1){1'b1}}};
  localparam logic [WACC-1:0] AMIN = {1'b1, {(WACC-1){1'b0}}};
  localparam logic [WO-1:0]   OMAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0]   OMIN = {1'b1, {(WO-1){1'b0}}};
  logic [WACC:0] sum_w;
  logic          sat_up_q, sat_up_d;
  logic          sat_dn_q, sat_dn_d;
`endif

  // Stage 1: data registers hold through idle cycles; the valid does not.
  always_comb begin
    en1_d   = i_en;
    prod_d  = prod_q;
    last1_d = last1_q;
    if (i_en) begin
      prod_d  = $signed(ina) * $signed(inb);
      last1_d = i_last;
    end
  end

  assign prod_ext = WACC'(prod_q);
  assign base     = first_q ? '0 : acc_q;

  // Stage 2: the first beat of a frame replaces the sum instead of adding to it.
  always_comb begin
    acc_d    = acc_q;
    first_d  = first_q;
    close2_d = en1_q & last1_q;
`ifdef FIXEDPOINT_MAC_ACC_SAT_EN
    sat_up_d = sat_up_q;
    sat_dn_d = sat_dn_q;
    sum_w    = {base[WACC-1], base} + {prod_ext[WACC-1], prod_ext};
`endif
    if (en1_q) begin
      first_d = last1_q;
`ifdef FIXEDPOINT_MAC_ACC_SAT_EN
      if (first_q) begin
        sat_up_d = 1'b0;
        sat_dn_d = 1'b0;
      end
      if (sum_w[WACC:WACC-1] == 2'b01) begin
        acc_d = AMAX;
        if (!(sat_up_d || sat_dn_d)) sat_up_d = 1'b1;
      end else if (sum_w[WACC:WACC-1] == 2'b10) begin
        acc_d = AMIN;
        if (!(sat_up_d || sat_dn_d)) sat_dn_d = 1'b1;
      end else begin
        acc_d = sum_w[WACC-1:0];
      end
`else
      acc_d = base + prod_ext;
`endif
    end
  end

  comb_FixedPointZoom #(
    .WII   (WRI + WGUARD),
    .WIF   (WRF),
    .WOI   (WOI),
    .WOF   (WOF),
    .ROOF  (ROOF),
    .ROUND (ROUND)
  ) u_zoom (
    .in       (acc_q),
    .out      (conv_out),
    .upflow   (conv_up),
    .downflow (conv_dn)
  );

  // Stage 3: results only change on frame close and hold otherwise.
  always_comb begin
    o_en_d = close2_q;
    out_d  = out_q;
    up_d   = up_q;
    dn_d   = dn_q;
    if (close2_q) begin
      out_d = conv_out;
      up_d  = conv_up;
      dn_d  = conv_dn;
`ifdef FIXEDPOINT_MAC_ACC_SAT_EN
      if (sat_up_q) begin
        out_d = OMAX;
        up_d  = 1'b1;
        dn_d  = 1'b0;
      end else if (sat_dn_q) begin
        out_d = OMIN;
        up_d  = 1'b0;
        dn_d  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_q   <= '0;
      en1_q    <= 1'b0;
      last1_q  <= 1'b0;
      acc_q    <= '0;
      first_q  <= 1'b1;
      close2_q <= 1'b0;
      o_en_q   <= 1'b0;
      out_q    <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      en1_q    <= en1_d;
      last1_q  <= last1_d;
      acc_q    <= acc_d;
      first_q  <= first_d;
      close2_q <= close2_d;
      o_en_q   <= o_en_d;
      out_q    <= out_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
    end
  end

`ifdef FIXEDPOINT_MAC_ACC_SAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_up_q <= 1'b0;
      sat_dn_q <= 1'b0;
    end else begin
      sat_up_q <= sat_up_d;
      sat_dn_q <= sat_dn_d;
    end
  end
`endif

  assign o_en     = o_en_q;
  assign out      = out_q;
  assign upflow   = up_q;
  assign downflow = dn_q;

endmodule

// File: tb/tb_pipe_fixedpoint_mac.sv
// tb/tb_pipe_fixedpoint_mac.sv - directed bench for pipe_fixedpoint_mac (default, ROOF=0 and ROUND=0 instances)
module tb_pipe_fixedpoint_mac;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_en = 1'b0;
  logic        i_last = 1'b0;
  logic [15:0] ina = '0;
  logic [15:0] inb = '0;
  logic [2:0]  o_en;
  logic [2:0]  up;
  logic [2:0]  dn;
  logic [15:0] outv [3];

  pipe_fixedpoint_mac u_dut (
    .rstn(rstn), .clk(clk), .i_en(i_en), .i_last(i_last), .ina(ina), .inb(inb),
    .o_en(o_en[0]), .out(outv[0]), .upflow(up[0]), .downflow(dn[0]));

  pipe_fixedpoint_mac #(.ROOF(0)) u_wrap (
    .rstn(rstn), .clk(clk), .i_en(i_en), .i_last(i_last), .ina(ina), .inb(inb),
    .o_en(o_en[1]), .out(outv[1]), .upflow(up[1]), .downflow(dn[1]));

  pipe_fixedpoint_mac #(.ROUND(0)) u_trunc (
    .rstn(rstn), .clk(clk), .i_en(i_en), .i_last(i_last), .ina(ina), .inb(inb),
    .o_en(o_en[2]), .out(outv[2]), .upflow(up[2]), .downflow(dn[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: frame sum in units of 2^-16, 36-bit accumulator range.
  localparam longint AMAX = (64'sd1 <<< 35) - 1;
  localparam longint AMIN = -(64'sd1 <<< 35);
  localparam longint AMOD = 64'sd1 <<< 36;

  typedef struct packed {
    int               due;
    logic [2:0][15:0] o;
    logic [2:0]       u;
    logic [2:0]       d;
  } exp_t;

  exp_t   q[$];
  exp_t   hold = '0;
  longint msum = 0;
  bit     mfirst = 1'b1;
  int     msticky = 0;
  bit     checking = 1'b0;
  logic [15:0] cap_out [3];
  logic [2:0]  cap_up = '0;
  logic [2:0]  cap_dn = '0;

  function automatic void conv(input longint s, input bit roof, input bit rnd,
                               output logic [15:0] o, output logic u, output logic d);
    longint v;
    v = rnd ? ((s + 128) >>> 8) : (s >>> 8);
    u = (v > 32767);
    d = (v < -32768);
    o = v[15:0];
    if (roof && u) o = 16'h7fff;
    else if (roof && d) o = 16'h8000;
  endfunction

  task automatic model_beat(input logic [15:0] a, input logic [15:0] b, input bit last);
    longint p;
    exp_t   e;
    p = longint'($signed(a)) * longint'($signed(b));
    if (mfirst) begin
      msum    = 0;
      msticky = 0;
    end
    msum = msum + p;
`ifdef FIXEDPOINT_MAC_ACC_SAT_EN
    if (msum > AMAX) begin
      msum = AMAX;
      if (msticky == 0) msticky = 1;
    end else if (msum < AMIN) begin
      msum = AMIN;
      if (msticky == 0) msticky = 2;
    end
`else
    if (msum > AMAX) msum = msum - AMOD;
    else if (msum < AMIN) msum = msum + AMOD;
`endif
    mfirst = last;
    if (last) begin
      e = '0;
      e.due = cyc + 3;
      for (int k = 0; k < 3; k++) begin
        logic [15:0] o;
        logic u, d;
        conv(msum, k != 1, k != 2, o, u, d);
        if (msticky == 1) begin o = 16'h7fff; u = 1'b1; d = 1'b0; end
        if (msticky == 2) begin o = 16'h8000; u = 1'b0; d = 1'b1; end
        e.o[k] = o;
        e.u[k] = u;
        e.d[k] = d;
      end
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      bit exp_en;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      exp_en = (q.size() > 0 && q[0].due == cyc);
      if (exp_en) hold = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("o_en[%0d]", k), 32'(o_en[k]), 32'(exp_en));
        chk($sformatf("out[%0d]", k), 32'(outv[k]), 32'(hold.o[k]));
        chk($sformatf("upflow[%0d]", k), 32'(up[k]), 32'(hold.u[k]));
        chk($sformatf("downflow[%0d]", k), 32'(dn[k]), 32'(hold.d[k]));
        if (o_en[k]) begin
          cap_out[k] = outv[k];
          cap_up[k]  = up[k];
          cap_dn[k]  = dn[k];
        end
      end
    end
  end

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input bit last);
    @(posedge clk); #1;
    i_en = 1'b1; i_last = last; ina = a; inb = b;
    model_beat(a, b, last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_en = 1'b0; i_last = 1'b1; ina = 16'hdead; inb = 16'hbeef;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s o_en[%0d]", tag, k), 32'(o_en[k]), 32'd0);
      chk($sformatf("%s out[%0d]", tag, k), 32'(outv[k]), 32'd0);
      chk($sformatf("%s up[%0d]", tag, k), 32'(up[k]), 32'd0);
      chk($sformatf("%s dn[%0d]", tag, k), 32'(dn[k]), 32'd0);
    end
  endtask

  task automatic lit(input string name, input int k, input logic [15:0] o,
                     input logic u, input logic d);
    chk({name, " out"}, 32'(cap_out[k]), 32'(o));
    chk({name, " up"}, 32'(cap_up[k]), 32'(u));
    chk({name, " dn"}, 32'(cap_dn[k]), 32'(d));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    hold = '0;
    checking = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic accumulation: 3 x (1.5 * 2.0) = 9.0
    beat(16'h0180, 16'h0200, 1'b0);
    beat(16'h0180, 16'h0200, 1'b0);
    beat(16'h0180, 16'h0200, 1'b1);
    idle(5);
    lit("basic", 0, 16'h0900, 1'b0, 1'b0);

    // Overflow: saturate vs wrap
    beat(16'h6400, 16'h0200, 1'b1);
    idle(5);
    lit("sat_up", 0, 16'h7fff, 1'b1, 1'b0);
    lit("wrap_up", 1, 16'hc800, 1'b1, 1'b0);
    beat(16'h8000, 16'h0200, 1'b1);
    idle(5);
    lit("sat_dn", 0, 16'h8000, 1'b0, 1'b1);

    // Rounding of 2^-9: half-up vs floor
    beat(16'h0001, 16'h0080, 1'b1);
    idle(5);
    lit("round", 0, 16'h0001, 1'b0, 1'b0);
    lit("trunc", 2, 16'h0000, 1'b0, 1'b0);
    beat(16'hffff, 16'h0080, 1'b1);
    idle(5);
    lit("round_neg", 0, 16'h0000, 1'b0, 1'b0);
    lit("trunc_neg", 2, 16'hffff, 1'b0, 1'b0);

    // Gap inside frame A, then frame B with no bubble
    beat(16'h0100, 16'h0300, 1'b0);
    idle(3);
    beat(16'h0200, 16'h0100, 1'b1);
    beat(16'h0080, 16'h0400, 1'b1);
    idle(5);
    lit("b2b", 0, 16'h0200, 1'b0, 1'b0);

    // Reset mid-frame discards the partial sum
    beat(16'h0100, 16'h0100, 1'b0);
    beat(16'h0100, 16'h0100, 1'b0);
    @(posedge clk); #1;
    i_en = 1'b0; i_last = 1'b0;
    rstn = 1'b0;
    mfirst = 1'b1;
    q.delete();
    hold = '0;
    #1;
    chk_zero("mid_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    beat(16'h0100, 16'h0100, 1'b1);
    idle(5);
    lit("after_reset", 0, 16'h0100, 1'b0, 1'b0);

    // Internal accumulator overflow: 40 x 16384
    for (int i = 0; i < 40; i++) beat(16'h8000, 16'h8000, i == 39);
    idle(5);
`ifdef FIXEDPOINT_MAC_ACC_SAT_EN
    lit("acc_ovf", 0, 16'h7fff, 1'b1, 1'b0);
`else
    lit("acc_ovf", 0, 16'h8000, 1'b0, 1'b1);
`endif

    // Mixed-sign frame: 2.0 + (-3.0) + 0.25 = -0.75
    beat(16'h0100, 16'h0200, 1'b0);
    beat(16'hff00, 16'h0300, 1'b0);
    beat(16'h0040, 16'h0100, 1'b1);
    idle(5);
    lit("mixed", 0, 16'hff40, 1'b0, 1'b0);

    chk("pending_results", 32'(q.size()), 32'd0);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
